// File: rtl/bus_pkg.sv
// Shared types and constants for the two-master serial bus arbiter.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT1    = 2'd1,
        GNT2    = 2'd2,
        RELEASE = 2'd3
    } bus_state_t;

    typedef enum logic {
        M1 = 1'b0,
        M2 = 1'b1
    } master_t;

    localparam int DEFAULT_TIMEOUT = 1023;

    // Round-robin choice: a tie goes to whichever master did not own the bus last.
    function automatic master_t rr_pick(input logic req1, input logic req2, input master_t last);
        if (req1 && req2) begin
            return (last == M1) ? M2 : M1;
        end
        return req1 ? M1 : M2;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Per-grant stall watchdog: counts owned cycles not held off by the slave,
// saturating at TIMEOUT; expired flags the cycle that completes the budget.
module bus_watchdog
    import bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic hold,
    output logic expired
);

    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;
    logic          step;

    assign step    = enable && !hold;
    // Fires during the TIMEOUT-th counted cycle so the bus is reclaimed on the
    // edge where the count would reach TIMEOUT.
    assign expired = step && (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (step && (count != LIMIT)) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with request muxing, response routing
// and a per-grant watchdog.
//
//   state   | meaning
//   IDLE    | no owner, waiting for a request
//   GNT1    | master 1 owns the bus
//   GNT2    | master 2 owns the bus
//   RELEASE | one dead cycle between owners, bus driven to 0
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m1_req,
    input  logic       m2_req,
    input  logic       m1_done,
    input  logic       m2_done,
    input  logic       m1_valid,
    input  logic       m1_wren,
    input  logic       m1_addr,
    input  logic       m1_data,
    input  logic       m1_burst,
    input  logic       m2_valid,
    input  logic       m2_wren,
    input  logic       m2_addr,
    input  logic       m2_data,
    input  logic       m2_burst,
    output logic       bus_valid,
    output logic       bus_wren,
    output logic       bus_addr,
    output logic       bus_data,
    output logic       bus_burst,
    output logic       BusAvailable,
    input  logic       s_ready,
    input  logic       s_validOut,
    input  logic       s_dataOut,
    input  logic       s_hold,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic       m1_ready,
    output logic       m1_rvalid,
    output logic       m1_rdata,
    output logic       m1_hold,
    output logic       m2_ready,
    output logic       m2_rvalid,
    output logic       m2_rdata,
    output logic       m2_hold,
    output logic       timeout_err,
    output logic [1:0] state_out
);

    bus_state_t state;
    master_t    last_grant;
    logic       in_grant;
    logic       expired;

    assign in_grant  = (state == GNT1) || (state == GNT2);
    assign state_out = state;

    // Held clear whenever nobody owns the bus, so every grant starts from zero.
    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_grant),
        .enable  (in_grant),
        .hold    (s_hold),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_grant   <= M2;
            m1_grant     <= 1'b0;
            m2_grant     <= 1'b0;
            BusAvailable <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE, RELEASE: begin
                    if (m1_req || m2_req) begin
                        BusAvailable <= 1'b1;
                        if (rr_pick(m1_req, m2_req, last_grant) == M1) begin
                            state      <= GNT1;
                            m1_grant   <= 1'b1;
                            m2_grant   <= 1'b0;
                            last_grant <= M1;
                        end else begin
                            state      <= GNT2;
                            m1_grant   <= 1'b0;
                            m2_grant   <= 1'b1;
                            last_grant <= M2;
                        end
                    end else begin
                        state        <= IDLE;
                        m1_grant     <= 1'b0;
                        m2_grant     <= 1'b0;
                        BusAvailable <= 1'b0;
                    end
                end
                GNT1: begin
                    if (m1_done || !m1_req || expired) begin
                        state        <= RELEASE;
                        m1_grant     <= 1'b0;
                        BusAvailable <= 1'b0;
                        timeout_err  <= expired && m1_req && !m1_done;
                    end
                end
                GNT2: begin
                    if (m2_done || !m2_req || expired) begin
                        state        <= RELEASE;
                        m2_grant     <= 1'b0;
                        BusAvailable <= 1'b0;
                        timeout_err  <= expired && m2_req && !m2_done;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        {bus_valid, bus_wren, bus_addr, bus_data, bus_burst} = '0;
        {m1_ready, m1_rvalid, m1_rdata, m1_hold}             = '0;
        {m2_ready, m2_rvalid, m2_rdata, m2_hold}             = '0;
        case (state)
            GNT1: begin
                {bus_valid, bus_wren, bus_addr, bus_data, bus_burst} =
                    {m1_valid, m1_wren, m1_addr, m1_data, m1_burst};
                {m1_ready, m1_rvalid, m1_rdata, m1_hold} = {s_ready, s_validOut, s_dataOut, s_hold};
            end
            GNT2: begin
                {bus_valid, bus_wren, bus_addr, bus_data, bus_burst} =
                    {m2_valid, m2_wren, m2_addr, m2_data, m2_burst};
                {m2_ready, m2_rvalid, m2_rdata, m2_hold} = {s_ready, s_validOut, s_dataOut, s_hold};
            end
            default: ;
        endcase
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter for the serial system bus. Grants bus ownership to one of two masters using round-robin, muxes the granted master's serial request lines (valid, write-enable, address, data, burst) onto the shared slave-facing bus, and routes slave responses (ready, read valid, read data, hold) back to the owner only. A per-grant watchdog reclaims the bus from a master that stalls.

## Interface
- `TIMEOUT`, 1023: max owned cycles (excluding slave-hold cycles) before forced release; must be ≥ 1
- `CW`, `$clog2(TIMEOUT+1)`: watchdog counter width (derived, not overridden)

Ports:
- `clk` in 1: bus clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; low forces reset state immediately
- `m1_req`, `m2_req` in 1 each: bus request, held high for whole transaction
- `m1_done`, `m2_done` in 1 each: one-cycle end-of-transaction pulse from owner
- `m1_valid`, `m1_wren`, `m1_addr`, `m1_data`, `m1_burst` in 1 each: master 1 serial request lines
- `m2_valid`, `m2_wren`, `m2_addr`, `m2_data`, `m2_burst` in 1 each: master 2 serial request lines
- `bus_valid`, `bus_wren`, `bus_addr`, `bus_data`, `bus_burst` out 1 each: muxed lines to slaves
- `BusAvailable` out 1: high while any grant is active; slaves may drive responses
- `s_ready`, `s_validOut`, `s_dataOut`, `s_hold` in 1 each: responses from addressed slave
- `m1_grant`, `m2_grant` out 1 each: registered grant, one-hot or zero
- `m1_ready`, `m1_rvalid`, `m1_rdata`, `m1_hold` out 1 each: routed responses to master 1
- `m2_ready`, `m2_rvalid`, `m2_rdata`, `m2_hold` out 1 each: routed responses to master 2
- `timeout_err` out 1: one-cycle pulse on watchdog release
- `state_out` out 2: current state, debug

## Operation
- States: IDLE=0, GNT1=1, GNT2=2, RELEASE=3.
- IDLE: one request → GNTx for that master. Both requests → GNT of master not equal to `last_grant`. None → stay.
- GNTx: exit to RELEASE on `mx_done`, on `mx_req` low, or on watchdog expiry; else stay.
- RELEASE: one dead cycle, all bus outputs 0; next edge: pending request(s) → GNT via same round-robin rule, else IDLE.
- `last_grant` register updates on every GNTx entry; reset value = master 2, so master 1 wins the first tie.
- Bus mux (combinational from state): GNT1 → master 1 lines; GNT2 → master 2 lines; IDLE/RELEASE → all 0.
- Response routing: owner gets `s_*` values; non-owner's ready/rvalid/rdata/hold held 0.
- Watchdog: cleared to 0 on GNT entry; +1 per GNT cycle with `s_hold` low; frozen while `s_hold` high; expiry when count == `TIMEOUT`; saturates, never wraps.
- `timeout_err` pulses in the cycle RELEASE is entered due to expiry only.

## Timing
- Reset values: state IDLE, grants 0, `BusAvailable` 0, `timeout_err` 0, watchdog 0, all bus/routed outputs 0, `state_out` 0.
- Grant latency: req high before edge N → grant and `BusAvailable` high after edge N.
- Release: done sampled at edge K → grant low after K; earliest next grant after edge K+1.
- Done and expiry same cycle: done wins, `timeout_err` stays 0.
- Req of non-owner changing during grant: no effect until RELEASE.
- `mx_done` from non-owner: ignored.
- Reset asserted mid-grant: outputs return to reset values asynchronously; in-flight transaction abandoned, no `timeout_err`.

## Structure
- `bus_pkg`: state encodings (IDLE/GNT1/GNT2/RELEASE), master ID constants (M1, M2), default `TIMEOUT`.
- One sub-module: `bus_watchdog` (clear, enable, hold-freeze, saturating count, `expired` output, parameter `TIMEOUT`).
- FSM, round-robin pick and muxes stay in `bus_arbiter`.

## Test plan
- Reset then `m1_req`=1 only → `m1_grant`=1 one cycle later, `bus_addr` follows `m1_addr`, `m2_ready` stays 0.
- Both reqs high from reset → M1 granted; `m1_done` at cycle 10 → one RELEASE cycle with bus 0, then M2 granted; M2 done → M1 granted again.
- `TIMEOUT`=8, M1 owns with no done → RELEASE after 8 owned cycles, `timeout_err`=1 for exactly one cycle.
- `TIMEOUT`=8, `s_hold`=1 for 5 cycles mid-grant → release after 13 owned cycles.
- `m1_done` on the exact expiry cycle → release, `timeout_err`=0.
- Reset low during GNT2 with `s_validOut`=1 → `m2_grant`, `m2_rvalid`, `BusAvailable` 0 immediately; after release, tie goes to M1.
